// File: rtl/cordic_arbiter_pkg.sv
// rtl/cordic_arbiter_pkg.sv - shared constants for the CORDIC arbiter slice
package cordic_arbiter_pkg;

    // Pipeline depth of the shared cordicg datapath for the default WIDTH.
    localparam int CORDIC_DELAY_DEFAULT = 20;

    // cordicg operation codes; the arbiter passes them through untouched.
    typedef enum logic [1:0] {
        OP_ROTATE = 2'd0,
        OP_VECTOR = 2'd1,
        OP_RSVD   = 2'd2,
        OP_FOLLOW = 2'd3
    } cordic_op_e;

    // Op presented to the CORDIC on cycles with no accepted request.
    localparam logic [1:0] OP_BUBBLE = OP_ROTATE;

endpackage

// File: rtl/cordic_rr_grant.sv
// rtl/cordic_rr_grant.sv - combinational round-robin grant over NREQ requesters
//
// Ports:
//   valid   - per-requester request valid
//   enable  - when low no grant is produced
//   last    - index of the most recently accepted requester
//   grant   - one-hot grant
//   index   - encoded index of the granted requester (0 when no grant)
module cordic_rr_grant #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic            enable,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   index
);

    // Search starts one past the last winner and wraps, so the previous
    // winner is considered last.
    always_comb begin
        int  c;
        logic found;
        c     = 0;
        found = 1'b0;
        grant = '0;
        index = '0;
        for (int k = 1; k <= NREQ; k++) begin
            c = (int'(last) + k) % NREQ;
            if (!found && enable && valid[c]) begin
                found    = 1'b1;
                grant[c] = 1'b1;
                index    = IW'(c);
            end
        end
    end

endmodule

// File: rtl/cordic_arbiter.sv
// rtl/cordic_arbiter.sv - shares one pipelined cordicg among NREQ requesters
//
// Ports:
//   clk_i, rst_n_i             - clock, asynchronous active-low reset
//   en_i                       - issue enable; low drains in-flight work
//   req_valid_i / req_ready_o  - per-requester handshake (ready is one-hot)
//   req_op_i/x_i/y_i/p_i       - packed per-requester operands
//   cordic_*_o                 - registered operands into cordicg
//   cordic_*_i                 - cordicg outputs
//   res_valid_o                - one-hot result strobe, one cycle wide
//   res_x_o/y_o/p_o            - shared result bus, holds between strobes
//   busy_o                     - work in flight or result being presented
//   issue_cnt_o                - accepted request count, wraps
module cordic_arbiter
    import cordic_arbiter_pkg::*;
#(
    parameter int WIDTH        = 18,
    parameter int NREQ         = 4,
    parameter int CORDIC_DELAY = CORDIC_DELAY_DEFAULT
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    en_i,
    input  logic [NREQ-1:0]         req_valid_i,
    output logic [NREQ-1:0]         req_ready_o,
    input  logic [2*NREQ-1:0]       req_op_i,
    input  logic [WIDTH*NREQ-1:0]   req_x_i,
    input  logic [WIDTH*NREQ-1:0]   req_y_i,
    input  logic [(WIDTH+1)*NREQ-1:0] req_p_i,
    output logic [1:0]              cordic_op_o,
    output logic [WIDTH-1:0]        cordic_x_o,
    output logic [WIDTH-1:0]        cordic_y_o,
    output logic [WIDTH:0]          cordic_p_o,
    input  logic [WIDTH-1:0]        cordic_x_i,
    input  logic [WIDTH-1:0]        cordic_y_i,
    input  logic [WIDTH:0]          cordic_p_i,
    output logic [NREQ-1:0]         res_valid_o,
    output logic [WIDTH-1:0]        res_x_o,
    output logic [WIDTH-1:0]        res_y_o,
    output logic [WIDTH:0]          res_p_o,
    output logic                    busy_o,
    output logic [31:0]             issue_cnt_o
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0]   last_grant;
    logic [NREQ-1:0] grant;
    logic [IW-1:0]   grant_idx;
    logic            accept;

    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_x;
    logic [WIDTH-1:0] sel_y;
    logic [WIDTH:0]   sel_p;

    // The issue register carries its own tag so that the CORDIC_DELAY-stage
    // line lines up with cordicg, which samples the issue register one edge
    // after the accept.
    logic                    issue_tag_v;
    logic [IW-1:0]           issue_tag_idx;
    logic [CORDIC_DELAY-1:0] tag_v;
    logic [IW-1:0]           tag_idx [CORDIC_DELAY];

    cordic_rr_grant #(.NREQ(NREQ), .IW(IW)) u_grant (
        .valid  (req_valid_i),
        .enable (en_i),
        .last   (last_grant),
        .grant  (grant),
        .index  (grant_idx)
    );

    assign req_ready_o = grant;
    assign accept      = |grant;
    assign busy_o      = issue_tag_v | (|tag_v) | (|res_valid_o);

    // Grant is one-hot, so a priority-free mux is enough.
    always_comb begin
        sel_op = OP_BUBBLE;
        sel_x  = '0;
        sel_y  = '0;
        sel_p  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_op = req_op_i[2*i +: 2];
                sel_x  = req_x_i[WIDTH*i +: WIDTH];
                sel_y  = req_y_i[WIDTH*i +: WIDTH];
                sel_p  = req_p_i[(WIDTH+1)*i +: WIDTH+1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            last_grant    <= IW'(NREQ - 1);
            issue_cnt_o   <= '0;
            cordic_op_o   <= OP_BUBBLE;
            cordic_x_o    <= '0;
            cordic_y_o    <= '0;
            cordic_p_o    <= '0;
            issue_tag_v   <= 1'b0;
            issue_tag_idx <= '0;
            tag_v         <= '0;
            for (int s = 0; s < CORDIC_DELAY; s++) tag_idx[s] <= '0;
            res_valid_o   <= '0;
            res_x_o       <= '0;
            res_y_o       <= '0;
            res_p_o       <= '0;
        end else begin
            if (accept) begin
                last_grant  <= grant_idx;
                issue_cnt_o <= issue_cnt_o + 32'd1;
            end
            // Unselected cycles load zeros (a bubble) via the mux defaults.
            cordic_op_o   <= sel_op;
            cordic_x_o    <= sel_x;
            cordic_y_o    <= sel_y;
            cordic_p_o    <= sel_p;
            issue_tag_v   <= accept;
            issue_tag_idx <= grant_idx;

            tag_v      <= {tag_v[CORDIC_DELAY-2:0], issue_tag_v};
            tag_idx[0] <= issue_tag_idx;
            for (int s = 1; s < CORDIC_DELAY; s++) tag_idx[s] <= tag_idx[s-1];

            if (tag_v[CORDIC_DELAY-1]) begin
                res_valid_o <= NREQ'(1) << tag_idx[CORDIC_DELAY-1];
                res_x_o     <= cordic_x_i;
                res_y_o     <= cordic_y_i;
                res_p_o     <= cordic_p_i;
            end else begin
                res_valid_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cordic_arbiter.sv
// tb/tb_cordic_arbiter.sv - directed self-checking bench for cordic_arbiter
module tb_cordic_arbiter;

    localparam int W = 18;
    localparam int N = 4;
    localparam int D = 20;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               en = 1'b0;
    logic [N-1:0]       req_valid = '0;
    logic [N-1:0]       req_ready;
    logic [2*N-1:0]     req_op = '0;
    logic [W*N-1:0]     req_x = '0;
    logic [W*N-1:0]     req_y = '0;
    logic [(W+1)*N-1:0] req_p = '0;
    logic [1:0]         cordic_op;
    logic [W-1:0]       cordic_x, cordic_y, cx_in, cy_in;
    logic [W:0]         cordic_p, cp_in;
    logic [N-1:0]       res_valid;
    logic [W-1:0]       res_x, res_y;
    logic [W:0]         res_p;
    logic               busy;
    logic [31:0]        issue_cnt;

    cordic_arbiter #(.WIDTH(W), .NREQ(N), .CORDIC_DELAY(D)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_op_i(req_op), .req_x_i(req_x), .req_y_i(req_y), .req_p_i(req_p),
        .cordic_op_o(cordic_op), .cordic_x_o(cordic_x), .cordic_y_o(cordic_y),
        .cordic_p_o(cordic_p),
        .cordic_x_i(cx_in), .cordic_y_i(cy_in), .cordic_p_i(cp_in),
        .res_valid_o(res_valid), .res_x_o(res_x), .res_y_o(res_y), .res_p_o(res_p),
        .busy_o(busy), .issue_cnt_o(issue_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in cordicg: D-stage pipeline with a simple known transform.
    logic [1:0]   m_op [D];
    logic [W-1:0] m_x [D], m_y [D];
    logic [W:0]   m_p [D];
    always @(posedge clk) begin
        m_op[0] <= cordic_op; m_x[0] <= cordic_x; m_y[0] <= cordic_y; m_p[0] <= cordic_p;
        for (int s = 1; s < D; s++) begin
            m_op[s] <= m_op[s-1]; m_x[s] <= m_x[s-1]; m_y[s] <= m_y[s-1]; m_p[s] <= m_p[s-1];
        end
    end
    assign cx_in = m_x[D-1] + W'(3 * int'(m_op[D-1]));
    assign cy_in = m_y[D-1] ^ 18'h000FF;
    assign cp_in = m_p[D-1] + 19'd1;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W:0]   p;
        int           cyc;
    } exp_t;

    exp_t         q [N][$];
    int           n_res [N];
    int           seq [N];
    logic [1:0]   c_op [N];
    logic [W-1:0] c_x [N], c_y [N];
    logic [W:0]   c_p [N];
    int           mode = 0;
    bit           pend = 0;
    logic [1:0]   p_op;
    logic [W-1:0] p_x, p_y;
    logic [W:0]   p_p;
    logic [N-1:0] g;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic gen(input int i);
        case (mode)
            1: begin
                c_op[i] = 2'd1;
                c_x[i]  = W'($urandom);
                c_y[i]  = W'($urandom);
                c_p[i]  = (W+1)'($urandom);
            end
            default: begin
                if (mode == 2) c_op[i] = (i == 0 && seq[i][0]) ? 2'd1 : 2'd3;
                else           c_op[i] = 2'(i % 3);
                c_x[i] = W'(1000 + seq[i] * 3 + i * 111);
                c_y[i] = W'(i * 37 + seq[i]);
                c_p[i] = (W+1)'(seq[i] * 5 + i);
            end
        endcase
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            q[i].delete();
            seq[i]   = 0;
            n_res[i] = 0;
            gen(i);
        end
        pend = 0;
    endtask

    // Called at a falling edge: check issue register, drive, note accepts.
    task automatic cycle(input logic [N-1:0] v, output logic [N-1:0] gr);
        exp_t e;
        if (pend) begin
            check("issue_op", 64'(cordic_op), 64'(p_op));
            check("issue_x", 64'(cordic_x), 64'(p_x));
            check("issue_y", 64'(cordic_y), 64'(p_y));
            check("issue_p", 64'(cordic_p), 64'(p_p));
        end else begin
            check("issue_bubble", 64'({cordic_op, cordic_x, cordic_y, cordic_p}), 64'd0);
        end
        req_valid = v;
        for (int i = 0; i < N; i++) begin
            req_op[2*i +: 2]       = c_op[i];
            req_x[W*i +: W]        = c_x[i];
            req_y[W*i +: W]        = c_y[i];
            req_p[(W+1)*i +: W+1]  = c_p[i];
        end
        #1;
        gr   = req_ready;
        pend = 0;
        for (int i = 0; i < N; i++) begin
            if (req_ready[i] && v[i]) begin
                e.x   = c_x[i] + W'(3 * int'(c_op[i]));
                e.y   = c_y[i] ^ 18'h000FF;
                e.p   = c_p[i] + 19'd1;
                e.cyc = cyc + D + 2;
                q[i].push_back(e);
                p_op = c_op[i]; p_x = c_x[i]; p_y = c_y[i]; p_p = c_p[i];
                pend = 1;
                seq[i]++;
                gen(i);
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        req_valid = '0;
        en        = 1'b1;
        rst_n     = 1'b0;
        @(negedge clk);
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) cycle('0, g);
    endtask

    // Result monitor: every strobe must match the oldest outstanding result.
    always @(negedge clk) begin
        if (rst_n && res_valid != '0) begin
            check("res_onehot", 64'($countones(res_valid) == 1), 64'd1);
            for (int i = 0; i < N; i++) begin
                if (res_valid[i]) begin
                    if (q[i].size() == 0) begin
                        check("orphan_result", 64'(res_valid[i]), 64'd0);
                    end else begin
                        exp_t e;
                        e = q[i].pop_front();
                        check("res_x", 64'(res_x), 64'(e.x));
                        check("res_y", 64'(res_y), 64'(e.y));
                        check("res_p", 64'(res_p), 64'(e.p));
                        check("res_latency", 64'(cyc), 64'(e.cyc));
                        n_res[i]++;
                    end
                end
            end
        end
    end

    initial begin
        clear_model();
        repeat (2) @(negedge clk);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);

        // Reset state and single request from requester 0.
        mode = 0;
        do_reset();
        check("rst_issue_cnt", 64'(issue_cnt), 64'd0);
        check("rst_cordic_x", 64'(cordic_x), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        cycle(4'b0001, g);
        check("single_grant", 64'(g), 64'h1);
        drain(30);
        check("single_n_res", 64'(n_res[0] + n_res[1] + n_res[2] + n_res[3]), 64'd1);
        check("single_cnt", 64'(issue_cnt), 64'd1);
        check("single_busy", 64'(busy), 64'd0);

        // All four requesting for 40 cycles.
        do_reset();
        for (int n = 0; n < 40; n++) begin
            cycle(4'b1111, g);
            check("rr_order", 64'(g), 64'(1 << (n % 4)));
        end
        check("rr_cnt", 64'(issue_cnt), 64'd40);
        drain(30);
        for (int i = 0; i < N; i++) check("rr_n_res", 64'(n_res[i]), 64'd10);

        // Requesters 1 and 3 with random operands, op 1.
        mode = 1;
        do_reset();
        for (int n = 0; n < 20; n++) begin
            cycle(4'b1010, g);
            check("alt_grant", 64'(g), (n % 2) ? 64'h8 : 64'h2);
        end
        drain(30);
        check("alt_n_res1", 64'(n_res[1]), 64'd10);
        check("alt_n_res3", 64'(n_res[3]), 64'd10);

        // Enable dropped after five accepts.
        mode = 0;
        do_reset();
        for (int n = 0; n < 5; n++) begin
            cycle(4'b0101, g);
            check("en_grant", 64'(g), (n % 2) ? 64'h4 : 64'h1);
        end
        en = 1'b0;
        cycle(4'b0101, g);
        check("en_low_busy", 64'(busy), 64'd1);
        for (int n = 0; n < 30; n++) begin
            cycle(4'b0101, g);
            check("en_low_ready", 64'(g), 64'd0);
        end
        check("en_n_res0", 64'(n_res[0]), 64'd3);
        check("en_n_res2", 64'(n_res[2]), 64'd2);
        check("en_cnt", 64'(issue_cnt), 64'd5);
        check("en_busy_after", 64'(busy), 64'd0);

        // Reset in the middle of operation.
        do_reset();
        for (int n = 0; n < 6; n++) cycle(4'b1111, g);
        drain(8);
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        check("midrst_res_valid", 64'(res_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_cnt", 64'(issue_cnt), 64'd0);
        check("midrst_cordic", 64'({cordic_op, cordic_x, cordic_y, cordic_p}), 64'd0);
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        drain(30);
        check("midrst_no_res", 64'(n_res[0] + n_res[1] + n_res[2] + n_res[3]), 64'd0);
        cycle(4'b1111, g);
        check("midrst_first_grant", 64'(g), 64'h1);
        drain(30);

        // Interleaved op 3 and op 1 from requesters 0 and 2.
        mode = 2;
        do_reset();
        for (int n = 0; n < 16; n++) cycle(4'b0101, g);
        drain(30);
        check("op_n_res0", 64'(n_res[0]), 64'd8);
        check("op_n_res2", 64'(n_res[2]), 64'd8);
        for (int i = 0; i < N; i++) check("left_over", 64'(q[i].size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cordic_arbiter.md
# cordic_arbiter

Shares one pipelined `cordicg` instance among NREQ requesters, one operation per clock. Requests are accepted by a round-robin arbiter and issued to the CORDIC inputs with a tag. The tag travels through a delay line matched to the CORDIC latency, so each result is routed back to the requester that issued it. It sits between per-channel DSP front-ends (phase/amplitude extraction, LO rotation) and a single shared CORDIC datapath.

## Interface
- `WIDTH`, 18: CORDIC x/y width; phase width is WIDTH+1.
- `NREQ`, 4: number of requesters, 2..8.
- `CORDIC_DELAY`, 20: cycles from a `cordicg` input sample to its output. Must equal the CORDIC's `cordic_delay` constant for the chosen WIDTH.
- `clk_i`  in  1  single clock.
- `rst_n_i`  in  1  asynchronous, active-low reset.
- `en_i`  in  1  issue enable; when low, no new grants and in-flight work drains.
- `req_valid_i`  in  NREQ  per-requester request valid.
- `req_ready_o`  out  NREQ  one-hot grant; a transfer happens when valid & ready.
- `req_op_i`  in  2*NREQ  CORDIC op per requester (slice i = bits 2i+1:2i).
- `req_x_i`, `req_y_i`  in  WIDTH*NREQ  operands, signed.
- `req_p_i`  in  (WIDTH+1)*NREQ  phase operand.
- `cordic_op_o`  out  2  to `cordicg` op input.
- `cordic_x_o`, `cordic_y_o`  out  WIDTH  to `cordicg` x/y inputs.
- `cordic_p_o`  out  WIDTH+1  to `cordicg` phase input.
- `cordic_x_i`, `cordic_y_i`  in  WIDTH  from `cordicg` outputs.
- `cordic_p_i`  in  WIDTH+1  from `cordicg` phase output.
- `res_valid_o`  out  NREQ  one-hot result strobe, one cycle wide.
- `res_x_o`, `res_y_o`  out  WIDTH  shared result bus.
- `res_p_o`  out  WIDTH+1  shared result bus.
- `busy_o`  out  1  any tag in flight, or a result currently presented.
- `issue_cnt_o`  out  32  total accepted requests, wraps modulo 2^32.

## Operation
- Grant logic:
  - Combinational round-robin over `req_valid_i` when `en_i`=1.
  - Priority starts at index (last_grant+1) mod NREQ.
  - `last_grant` updates only on an accepted transfer; reset value NREQ-1, so index 0 wins first.
- No backpressure from the result side. The CORDIC pipeline always advances and requesters must absorb `res_valid_o` unconditionally.
- Issue register: on the accepting edge, latch the granted requester's op/x/y/p into the `cordic_*_o` registers.
  - With no grant, load op=0, x=y=0, p=0 (bubble).
- Tag delay line: CORDIC_DELAY stages of {valid, index[$clog2(NREQ)-1:0]}, loaded in the same edge as the issue register.
- Result register: when the tag at the delay-line output is valid, latch `cordic_*_i` into `res_*_o` and set bit `index` of `res_valid_o`.
  - Otherwise `res_valid_o`=0 and the `res_*_o` buses hold their last values.
- Op values pass through unchanged, including op 3 (slave/follow mode) interleaved with other ops.
- `issue_cnt_o` increments by one per accepted transfer.

## Timing
- Reset (async assert, sync release): all outputs 0, all tags invalid, `last_grant`=NREQ-1.
- `req_ready_o` is combinational from `req_valid_i`, `en_i` and `last_grant`. It may depend on valid; requesters must not make valid depend on ready.
- Latency:
  - Accept at edge k → `cordic_*_o` valid after edge k.
  - Result enters the CORDIC output at edge k+CORDIC_DELAY.
  - `res_valid_o` is high for the cycle after edge k+CORDIC_DELAY+1.
  - Total: CORDIC_DELAY+1 cycles, no gaps for back-to-back issue.
- Throughput: one accept per cycle total. With all NREQ requesting, each is granted once per NREQ cycles.
- `en_i` low mid-stream: no accept, bubbles are issued, and already-issued tags still deliver results. `busy_o` falls the cycle after the last result strobe.
- Reset mid-operation: in-flight tags are discarded and no `res_valid_o` is produced for them.
- Single requester continuously valid: granted every cycle.

## Structure
- Sub-module `cordic_rr_grant`: parameter NREQ; inputs valid, enable, last index; outputs one-hot grant and encoded index.
- The CORDIC_DELAY value comes from the CORDIC's shared header constant `cordic_delay`. No new package is needed.
- The tag delay line is a plain shift register in the top module; no RAM.

## Test plan
- Reset, then requester 0 alone sends x=1000, y=0, p=0, op=0 → exactly one `res_valid_o`=0001 pulse, 21 cycles after accept (CORDIC_DELAY=20), with `res_x_o` equal to the standalone `cordicg` output.
- All 4 requesters valid for 40 cycles → grants cycle 0,1,2,3,0,…, `issue_cnt_o`=40, and each requester receives 10 results in issue order with matching operands.
- Requesters 1 and 3 only, with random x/y and op=1 → results tagged 0010/1000 alternate, and each equals a reference CORDIC fed the same stream.
- `en_i` dropped after 5 accepts → no further ready, 5 results still arrive, `busy_o` low afterward.
- Assert `rst_n_i` 8 cycles after 6 accepts → outputs 0 immediately, no result strobes after release, first grant goes to index 0.
- Interleave op=3 and op=1 from two requesters → op reaches `cordic_op_o` unchanged and results route to the correct requesters.
